// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : branch_sequencer
// Brief    : SPARC V8 PC/nPC sequencer. Evaluates all 16 Bicc conditions
//            against icc, computes branch targets, implements delay-slot
//            annulment through the a bit and accepts trap redirects.
// Revision : 1.0 - initial release
// ============================================================================
module branch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                ANNUL_EN = 1
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              step,
  input  logic [31:0]       ir,
  input  logic [3:0]        icc,
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] npc_out,
  output logic              annul_out,
  output logic              cond_out,
  output logic              branch_taken
);

  localparam logic [ADDR_W-1:0] C_FOUR      = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] C_RESET_NPC = RESET_PC + C_FOUR;
  localparam logic [3:0]        C_COND_BA   = 4'b1000;

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    SLOT_ANNUL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic              branch_taken_q, branch_taken_d;

  // Instruction fields
  logic              is_bicc;
  logic              a_bit;
  logic [3:0]        cond;
  logic [21:0]       disp22;
  logic              flag_n, flag_z, flag_v, flag_c;
  logic              cond_true;
  logic [ADDR_W-1:0] disp_ext;
  logic [ADDR_W-1:0] target;
  logic              annul_allowed;

  assign is_bicc       = (ir[31:30] == 2'b00) && (ir[24:22] == 3'b010);
  assign a_bit         = ir[29];
  assign cond          = ir[28:25];
  assign disp22        = ir[21:0];
  assign {flag_n, flag_z, flag_v, flag_c} = icc;
  assign annul_allowed = (ANNUL_EN != 0) && a_bit;

  // Evaluate the condition; bit 3 of cond inverts the base test of cond[2:0]
  always_comb begin
    logic base;
    base = 1'b0;
    unique case (cond[2:0])
      3'b000: base = 1'b0;
      3'b001: base = flag_z;
      3'b010: base = flag_z | (flag_n ^ flag_v);
      3'b011: base = flag_n ^ flag_v;
      3'b100: base = flag_c | flag_z;
      3'b101: base = flag_c;
      3'b110: base = flag_n;
      3'b111: base = flag_v;
      default: base = 1'b0;
    endcase
    cond_true = base ^ cond[3];
  end

  // Target is relative to the branch's own PC; shift drops the top bits
  assign disp_ext = {{(ADDR_W-22){disp22[21]}}, disp22} << 2;
  assign target   = pc_q + disp_ext;

  // Next-state and next-PC selection; trap outranks step in either state
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    npc_d          = npc_q;
    branch_taken_d = 1'b0;
    if (trap_valid) begin
      pc_d    = trap_addr;
      npc_d   = trap_addr + C_FOUR;
      state_d = RUN;
    end else if (step) begin
      pc_d  = npc_q;
      npc_d = npc_q + C_FOUR;
      if (state_q == SLOT_ANNUL) begin
        // Annulled slot: ir is never treated as a branch
        state_d = RUN;
      end else if (is_bicc) begin
        if (cond_true) begin
          npc_d          = target;
          branch_taken_d = 1'b1;
          // Only an unconditional taken branch annuls its slot
          if (annul_allowed && (cond == C_COND_BA)) begin
            state_d = SLOT_ANNUL;
          end
        end else if (annul_allowed) begin
          state_d = SLOT_ANNUL;
        end
      end
    end
  end

  // State and PC registers with asynchronous active-low reset
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      npc_q          <= C_RESET_NPC;
      branch_taken_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      npc_q          <= npc_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  assign pc_out       = pc_q;
  assign npc_out      = npc_q;
  assign annul_out    = (state_q == SLOT_ANNUL);
  assign branch_taken = branch_taken_q;
  assign cond_out     = is_bicc & cond_true;

endmodule
`default_nettype wire

// File: tb/tb_branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_sequencer
// Brief    : Self-checking bench for branch_sequencer (directed table,
//            full condition sweep with reference model, async reset case).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_sequencer;

  localparam int ADDR_W = 32;

  logic              Clk;
  logic              RESET;
  logic              step;
  logic [31:0]       ir;
  logic [3:0]        icc;
  logic              trap_valid;
  logic [ADDR_W-1:0] trap_addr;
  logic [ADDR_W-1:0] pc_out, npc_out, pc_out0, npc_out0;
  logic              annul_out, cond_out, branch_taken;
  logic              annul_out0, cond_out0, branch_taken0;

  int errors = 0;
  int checks = 0;

  branch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC('0), .ANNUL_EN(1)) dut (
    .Clk(Clk), .RESET(RESET), .step(step), .ir(ir), .icc(icc),
    .trap_valid(trap_valid), .trap_addr(trap_addr),
    .pc_out(pc_out), .npc_out(npc_out), .annul_out(annul_out),
    .cond_out(cond_out), .branch_taken(branch_taken)
  );

  branch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC('0), .ANNUL_EN(0)) dut_noannul (
    .Clk(Clk), .RESET(RESET), .step(step), .ir(ir), .icc(icc),
    .trap_valid(trap_valid), .trap_addr(trap_addr),
    .pc_out(pc_out0), .npc_out(npc_out0), .annul_out(annul_out0),
    .cond_out(cond_out0), .branch_taken(branch_taken0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  icc;
    logic        step;
    logic        trap;
    logic [31:0] taddr;
    logic        chk_cond;
    logic        cond;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        ann;
    logic        bt;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        ann;
    logic        bt;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference condition table from the Bicc mnemonic list
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      4'b0000: return 1'b0;
      4'b1000: return 1'b1;
      4'b0001: return z;
      4'b1001: return !z;
      4'b0010: return z | (n ^ v);
      4'b1010: return !(z | (n ^ v));
      4'b0011: return n ^ v;
      4'b1011: return !(n ^ v);
      4'b0100: return cy | z;
      4'b1100: return !(cy | z);
      4'b0101: return cy;
      4'b1101: return !cy;
      4'b0110: return n;
      4'b1110: return !n;
      4'b0111: return v;
      default: return !v;
    endcase
  endfunction

  // Called at a falling edge; drives one cycle and compares the result at the next falling edge
  task automatic apply(input string name, input vec_t v, input logic chk_ann0);
    exp_t e;
    ir = v.ir; icc = v.icc; step = v.step; trap_valid = v.trap; trap_addr = v.taddr;
    #1;
    if (v.chk_cond) check({name, " cond_out"}, 64'(cond_out), 64'(v.cond));
    e.name = name; e.pc = v.pc; e.npc = v.npc; e.ann = v.ann; e.bt = v.bt;
    sb.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    step = 1'b0; trap_valid = 1'b0;
    e = sb.pop_front();
    check({e.name, " pc"},    64'(pc_out),       64'(e.pc));
    check({e.name, " npc"},   64'(npc_out),      64'(e.npc));
    check({e.name, " annul"}, 64'(annul_out),    64'(e.ann));
    check({e.name, " bt"},    64'(branch_taken), 64'(e.bt));
    if (chk_ann0) check({e.name, " annul(ANNUL_EN=0)"}, 64'(annul_out0), 64'd0);
  endtask

  initial begin
    logic [31:0] mpc, mnpc, d, tgt;
    logic        tk;
    vec_t        v;

    //         ir            icc  st tr taddr  cc cnd pc           npc          ann bt
    vecs[0]  = '{32'h0280_0003, 4'h0, 1, 0, 32'h0,  1, 0, 32'h4,        32'h8,        0, 0};
    vecs[1]  = '{32'h3080_0003, 4'h0, 1, 0, 32'h0,  1, 1, 32'h8,        32'h10,       1, 1};
    vecs[2]  = '{32'h3080_0003, 4'h0, 1, 0, 32'h0,  0, 0, 32'h10,       32'h14,       0, 0};
    vecs[3]  = '{32'h3280_0002, 4'h0, 1, 0, 32'h0,  1, 1, 32'h14,       32'h18,       0, 1};
    vecs[4]  = '{32'h2280_0005, 4'h0, 1, 0, 32'h0,  1, 0, 32'h18,       32'h1C,       1, 0};
    vecs[5]  = '{32'h0100_0000, 4'h0, 1, 0, 32'h0,  1, 0, 32'h1C,       32'h20,       0, 0};
    vecs[6]  = '{32'h2280_0005, 4'h0, 1, 0, 32'h0,  1, 0, 32'h20,       32'h24,       1, 0};
    vecs[7]  = '{32'h3080_0003, 4'h0, 1, 1, 32'h40, 0, 0, 32'h40,       32'h44,       0, 0};
    vecs[8]  = '{32'h0100_0000, 4'h0, 0, 1, 32'h0,  1, 0, 32'h0,        32'h4,        0, 0};
    vecs[9]  = '{32'h10BF_FFFF, 4'h0, 1, 0, 32'h0,  1, 1, 32'h4,        32'hFFFF_FFFC, 0, 1};
    vecs[10] = '{32'h0100_0000, 4'h0, 0, 0, 32'h0,  1, 0, 32'h4,        32'hFFFF_FFFC, 0, 0};
    vecs[11] = '{32'h0100_0000, 4'h0, 1, 0, 32'h0,  1, 0, 32'hFFFF_FFFC, 32'h0,        0, 0};
    vecs[12] = '{32'h2080_0000, 4'h0, 1, 0, 32'h0,  1, 0, 32'h0,        32'h4,        1, 0};
    vecs[13] = '{32'h0100_0000, 4'h0, 1, 0, 32'h0,  1, 0, 32'h4,        32'h8,        0, 0};

    RESET = 1'b0; step = 1'b0; ir = '0; icc = '0; trap_valid = 1'b0; trap_addr = '0;
    repeat (2) @(negedge Clk);
    check("reset pc",    64'(pc_out),       64'h0);
    check("reset npc",   64'(npc_out),      64'h4);
    check("reset annul", 64'(annul_out),    64'h0);
    check("reset bt",    64'(branch_taken), 64'h0);
    RESET = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply($sformatf("vec%0d", i), vecs[i], 1'b1);
    end

    // Condition sweep from a known base, a=0, reference model predicts results
    v = '{32'h0, 4'h0, 0, 1, 32'h1000, 0, 0, 32'h1000, 32'h1004, 0, 0};
    apply("sweep base", v, 1'b0);
    mpc = 32'h1000; mnpc = 32'h1004;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        d   = 32'(c * 16 + f + 1);
        tk  = ref_cond(4'(c), 4'(f));
        tgt = mpc + (d << 2);
        v.ir = {2'b00, 1'b0, 4'(c), 3'b010, d[21:0]};
        v.icc = 4'(f); v.step = 1'b1; v.trap = 1'b0; v.taddr = '0;
        v.chk_cond = 1'b1; v.cond = tk;
        v.pc = mnpc; v.npc = tk ? tgt : mnpc + 32'd4; v.ann = 1'b0; v.bt = tk;
        apply($sformatf("sweep c%0d f%0d", c, f), v, 1'b0);
        mpc = v.pc; mnpc = v.npc;
      end
    end

    // Asynchronous reset while in the annulled slot with branch_taken high
    v = '{32'h0, 4'h0, 0, 1, 32'h200, 0, 0, 32'h200, 32'h204, 0, 0};
    apply("pre-reset trap", v, 1'b0);
    v = '{32'h3080_0003, 4'h0, 1, 0, 32'h0, 1, 1, 32'h204, 32'h20C, 1, 1};
    apply("pre-reset BA,a", v, 1'b0);
    #2;
    RESET = 1'b0;
    #1;
    check("async reset pc",    64'(pc_out),       64'h0);
    check("async reset npc",   64'(npc_out),      64'h4);
    check("async reset annul", 64'(annul_out),    64'h0);
    check("async reset bt",    64'(branch_taken), 64'h0);
    @(negedge Clk);
    RESET = 1'b1;
    v = '{32'h0100_0000, 4'h0, 1, 0, 32'h0, 1, 0, 32'h4, 32'h8, 0, 0};
    apply("post-reset step", v, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
